rx_block_sync_descrambler: RTL and testbench

Receive-side counterpart of the 64-bit 10GBASE-R scrambler (G(x) = x^58 + x^39 + 1). It sits between the SERDES gearbox output and the 64b/66b decoder. It acquires and holds 66-bit block lock from the 2-bit sync headers, requesting bit slips from the gearbox while hunting. It also self-synchronously descrambles the 64-bit payload and flags header errors.

---
 rtl/eth_rx_pkg.sv | 20 ++
 rtl/descrambler_64bit_ff.sv | 32 +++
 rtl/rx_block_sync_descrambler.sv | 195 +++++++++++++++++++
 tb/tb_rx_block_sync_descrambler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the 10GBASE-R receive block sync path.
package eth_rx_pkg;

   typedef enum logic [1:0] {
      HUNT,
      SLIP,
      LOCKED
   } lock_state_e;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam int TAP_A = 39;
   localparam int TAP_B = 58;

   function automatic logic hdr_valid(input logic [1:0] h);
      return (h == SYNC_DATA) || (h == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/descrambler_64bit_ff.sv
// Self-synchronizing x^58+x^39+1 descrambler, 64 bits per block.
module descrambler_64bit_ff
   import eth_rx_pkg::*;
(
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        en,
   input  logic [63:0] din,
   output logic [63:0] dout
);

   logic [57:0]  s_q, s_d;
   logic [121:0] x;

   // x[k] holds wire bit k-58 relative to this block
   assign x = {din, s_q};

   for (genvar i = 0; i < 64; i++) begin : g_bit
      assign dout[i] = x[i+TAP_B] ^ x[i+TAP_B-TAP_A] ^ x[i];
   end

   always_comb begin
      s_d = s_q;
      if (en) s_d = din[63:6];
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) s_q <= '1;
      else        s_q <= s_d;
   end

endmodule

// File: rtl/rx_block_sync_descrambler.sv
// 64b/66b receive block lock FSM plus payload descrambler.
// Optional BER monitor is built when RX_BER_MON_EN is defined.
module rx_block_sync_descrambler
   import eth_rx_pkg::*;
#(
   parameter int LOCK_CNT     = 64,
   parameter int BAD_LIMIT    = 16,
   parameter int WINDOW       = 64,
   parameter int SLIP_HOLDOFF = 4
`ifdef RX_BER_MON_EN
  ,parameter int BER_WINDOW   = 19531
`endif
)(
   input  logic        CLK,
   input  logic        rst_n,
   input  logic [63:0] serdes_rx_data,
   input  logic [1:0]  serdes_rx_hdr,
   input  logic        serdes_rx_valid,
   output logic [63:0] rx_data,
   output logic [1:0]  rx_hdr,
   output logic        rx_valid,
   output logic        rx_hdr_err,
   output logic        rx_bitslip,
   output logic        rx_block_lock,
   output logic        rx_high_ber
);

   localparam int SH_W = $clog2(LOCK_CNT + 1);
   localparam int SL_W = $clog2(SLIP_HOLDOFF + 1);
   localparam int WN_W = $clog2(WINDOW + 1);
   localparam int BD_W = $clog2(BAD_LIMIT + 1);

   localparam logic [SH_W-1:0] SH_LAST = SH_W'(LOCK_CNT - 1);
   localparam logic [SL_W-1:0] SL_LAST = SL_W'(SLIP_HOLDOFF - 1);
   localparam logic [WN_W-1:0] WN_LAST = WN_W'(WINDOW - 1);
   localparam logic [BD_W-1:0] BD_LAST = BD_W'(BAD_LIMIT - 1);

   lock_state_e     state_q, state_d;
   logic [SH_W-1:0] sh_cnt_q, sh_cnt_d;
   logic [SL_W-1:0] slip_cnt_q, slip_cnt_d;
   logic [WN_W-1:0] win_cnt_q, win_cnt_d;
   logic [BD_W-1:0] bad_cnt_q, bad_cnt_d;
   logic [63:0]     rx_data_q, rx_data_d, desc_data;
   logic [1:0]      rx_hdr_q, rx_hdr_d;
   logic            rx_valid_q, rx_valid_d;
   logic            rx_hdr_err_q, rx_hdr_err_d;
   logic            rx_bitslip_q, rx_bitslip_d;
   logic            hdr_ok;

   assign hdr_ok = hdr_valid(serdes_rx_hdr);

   descrambler_64bit_ff u_desc (
      .CLK   (CLK),
      .rst_n (rst_n),
      .en    (serdes_rx_valid),
      .din   (serdes_rx_data),
      .dout  (desc_data)
   );

   always_comb begin
      state_d      = state_q;
      sh_cnt_d     = sh_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      win_cnt_d    = win_cnt_q;
      bad_cnt_d    = bad_cnt_q;
      rx_bitslip_d = 1'b0;
      rx_valid_d   = serdes_rx_valid;
      rx_hdr_err_d = serdes_rx_valid & ~hdr_ok;
      rx_data_d    = serdes_rx_valid ? desc_data : rx_data_q;
      rx_hdr_d     = serdes_rx_valid ? serdes_rx_hdr : rx_hdr_q;
      if (serdes_rx_valid) begin
         unique case (state_q)
            HUNT: begin
               if (!hdr_ok) begin
                  rx_bitslip_d = 1'b1;
                  sh_cnt_d     = '0;
                  slip_cnt_d   = '0;
                  state_d      = SLIP;
               end else if (sh_cnt_q == SH_LAST) begin
                  sh_cnt_d  = '0;
                  win_cnt_d = '0;
                  bad_cnt_d = '0;
                  state_d   = LOCKED;
               end else begin
                  sh_cnt_d = sh_cnt_q + 1'b1;
               end
            end
            SLIP: begin
               if (slip_cnt_q == SL_LAST) begin
                  slip_cnt_d = '0;
                  sh_cnt_d   = '0;
                  state_d    = HUNT;
               end else begin
                  slip_cnt_d = slip_cnt_q + 1'b1;
               end
            end
            LOCKED: begin
               // Loss of lock takes priority over a window rollover
               if (!hdr_ok && bad_cnt_q == BD_LAST) begin
                  rx_bitslip_d = 1'b1;
                  win_cnt_d    = '0;
                  bad_cnt_d    = '0;
                  slip_cnt_d   = '0;
                  state_d      = SLIP;
               end else if (win_cnt_q == WN_LAST) begin
                  win_cnt_d = '0;
                  bad_cnt_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
                  bad_cnt_d = bad_cnt_q + BD_W'(!hdr_ok);
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         sh_cnt_q     <= '0;
         slip_cnt_q   <= '0;
         win_cnt_q    <= '0;
         bad_cnt_q    <= '0;
         rx_data_q    <= '0;
         rx_hdr_q     <= '0;
         rx_valid_q   <= 1'b0;
         rx_hdr_err_q <= 1'b0;
         rx_bitslip_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_cnt_q     <= sh_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         win_cnt_q    <= win_cnt_d;
         bad_cnt_q    <= bad_cnt_d;
         rx_data_q    <= rx_data_d;
         rx_hdr_q     <= rx_hdr_d;
         rx_valid_q   <= rx_valid_d;
         rx_hdr_err_q <= rx_hdr_err_d;
         rx_bitslip_q <= rx_bitslip_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_hdr        = rx_hdr_q;
   assign rx_valid      = rx_valid_q;
   assign rx_hdr_err    = rx_hdr_err_q;
   assign rx_bitslip    = rx_bitslip_q;
   assign rx_block_lock = (state_q == LOCKED);

`ifdef RX_BER_MON_EN
   localparam int BW_W = $clog2(BER_WINDOW + 1);
   localparam logic [BW_W-1:0] BW_LAST = BW_W'(BER_WINDOW - 1);
   localparam logic [4:0] BER_LIM = 5'd16;

   logic [BW_W-1:0] ber_blk_q, ber_blk_d;
   logic [4:0]      ber_err_q, ber_err_d;
   logic            high_ber_q, high_ber_d;

   // Flag sets as soon as the limit is hit; only a window boundary clears it
   always_comb begin
      ber_blk_d  = ber_blk_q;
      ber_err_d  = ber_err_q;
      high_ber_d = high_ber_q;
      if (serdes_rx_valid) begin
         if (!hdr_ok && ber_err_q != BER_LIM) ber_err_d = ber_err_q + 1'b1;
         if (ber_err_d == BER_LIM) high_ber_d = 1'b1;
         if (ber_blk_q == BW_LAST) begin
            high_ber_d = (ber_err_d == BER_LIM);
            ber_blk_d  = '0;
            ber_err_d  = '0;
         end else begin
            ber_blk_d = ber_blk_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         ber_blk_q  <= '0;
         ber_err_q  <= '0;
         high_ber_q <= 1'b0;
      end else begin
         ber_blk_q  <= ber_blk_d;
         ber_err_q  <= ber_err_d;
         high_ber_q <= high_ber_d;
      end
   end

   assign rx_high_ber = high_ber_q;
`else
   assign rx_high_ber = 1'b0;
`endif

endmodule

// File: tb/tb_rx_block_sync_descrambler.sv
// Bench for rx_block_sync_descrambler: scrambler model feeds a scoreboard queue.
module tb_rx_block_sync_descrambler;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] serdes_rx_data;
   logic [1:0]  serdes_rx_hdr;
   logic        serdes_rx_valid;
   logic [63:0] rx_data;
   logic [1:0]  rx_hdr;
   logic        rx_valid, rx_hdr_err, rx_bitslip, rx_block_lock, rx_high_ber;

   always #5 CLK = ~CLK;

   rx_block_sync_descrambler dut (
      .CLK             (CLK),
      .rst_n           (rst_n),
      .serdes_rx_data  (serdes_rx_data),
      .serdes_rx_hdr   (serdes_rx_hdr),
      .serdes_rx_valid (serdes_rx_valid),
      .rx_data         (rx_data),
      .rx_hdr          (rx_hdr),
      .rx_valid        (rx_valid),
      .rx_hdr_err      (rx_hdr_err),
      .rx_bitslip      (rx_bitslip),
      .rx_block_lock   (rx_block_lock),
      .rx_high_ber     (rx_high_ber)
   );

   typedef struct {
      logic [63:0] data;
      logic [1:0]  hdr;
      logic        err;
      logic        slip;
      logic        lock;
      logic        chk;
   } exp_t;

   typedef struct {
      logic [1:0] hdr;
      logic       slip;
      logic       lock;
   } vec_t;

   exp_t        q[$];
   exp_t        me;
   vec_t        tbl[8];
   int          n_chk = 0, n_pass = 0;
   int          slips = 0, errs = 0, s0, e0, nblk = 0;
   logic [57:0] scr_st = '1;
   logic [63:0] plain = 64'h9bd3c750ce28aac0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   always @(negedge CLK) begin
      if (rst_n && rx_valid) begin
         errs  += int'(rx_hdr_err);
         slips += int'(rx_bitslip);
         n_chk++;
         if (q.size() == 0) begin
            $display("FAIL extra_block: got unexpected output block");
         end else begin
            me = q.pop_front();
            if (rx_hdr === me.hdr && rx_hdr_err === me.err &&
                rx_bitslip === me.slip && rx_block_lock === me.lock &&
                (!me.chk || rx_data === me.data))
               n_pass++;
            else
               $display("FAIL block: got d=%h h=%b e=%b s=%b l=%b expected d=%h h=%b e=%b s=%b l=%b",
                        rx_data, rx_hdr, rx_hdr_err, rx_bitslip, rx_block_lock,
                        me.data, me.hdr, me.err, me.slip, me.lock);
         end
      end else if (rst_n && rx_bitslip) begin
         n_chk++;
         $display("FAIL stray_bitslip: got 1 expected 0");
      end
   end

   task automatic blk(input logic [1:0] h, input logic el, input logic es);
      exp_t         e;
      logic [121:0] x;
      logic [63:0]  p;
      p = plain;
      plain = {$urandom(), $urandom()};
      x = '0;
      x[57:0] = scr_st;
      for (int i = 0; i < 64; i++) x[i+58] = p[i] ^ x[i+19] ^ x[i];
      scr_st = x[121:64];
      @(posedge CLK); #1;
      serdes_rx_data  = x[121:58];
      serdes_rx_hdr   = h;
      serdes_rx_valid = 1'b1;
      e.data = p;
      e.hdr  = h;
      e.err  = (h == 2'b00) || (h == 2'b11);
      e.slip = es;
      e.lock = el;
      e.chk  = (nblk > 0);
      nblk++;
      q.push_back(e);
   endtask

   task automatic gap();
      @(posedge CLK); #1;
      serdes_rx_valid = 1'b0;
   endtask

   task automatic drain();
      gap();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
      @(negedge CLK);
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_data"}, rx_data, 64'd0);
      chk({pfx, "_hdr"}, 64'(rx_hdr), 64'd0);
      chk({pfx, "_valid"}, 64'(rx_valid), 64'd0);
      chk({pfx, "_hdr_err"}, 64'(rx_hdr_err), 64'd0);
      chk({pfx, "_bitslip"}, 64'(rx_bitslip), 64'd0);
      chk({pfx, "_lock"}, 64'(rx_block_lock), 64'd0);
      chk({pfx, "_high_ber"}, 64'(rx_high_ber), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      serdes_rx_valid = 1'b0;
      rst_n = 1'b0;
      q.delete();
      nblk = 0;
      #2;
      chk_zero("reset");
      @(posedge CLK); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      serdes_rx_data  = '0;
      serdes_rx_hdr   = '0;
      serdes_rx_valid = 1'b0;
      tbl[0] = '{2'b01, 1'b0, 1'b0};
      tbl[1] = '{2'b10, 1'b0, 1'b0};
      tbl[2] = '{2'b00, 1'b1, 1'b0};
      tbl[3] = '{2'b11, 1'b0, 1'b0};
      tbl[4] = '{2'b01, 1'b0, 1'b0};
      tbl[5] = '{2'b00, 1'b0, 1'b0};
      tbl[6] = '{2'b01, 1'b0, 1'b0};
      tbl[7] = '{2'b11, 1'b1, 1'b0};

      do_reset();
      for (int i = 0; i < 8; i++) blk(tbl[i].hdr, tbl[i].lock, tbl[i].slip);
      drain();

      // lock acquisition with idle gaps
      do_reset();
      s0 = slips;
      for (int i = 0; i < 70; i++) begin
         if (i % 13 == 5) gap();
         blk((i % 3 == 0) ? 2'b10 : 2'b01, i >= 63, 1'b0);
      end
      drain();
      chk("acq_lock", 64'(rx_block_lock), 64'd1);
      chk("acq_slips", 64'(slips - s0), 64'd0);

      // misalignment on block 10
      do_reset();
      s0 = slips;
      for (int i = 0; i < 9; i++) blk(2'b01, 1'b0, 1'b0);
      blk(2'b11, 1'b0, 1'b1);
      blk(2'b01, 1'b0, 1'b0);
      blk(2'b00, 1'b0, 1'b0);
      blk(2'b10, 1'b0, 1'b0);
      blk(2'b01, 1'b0, 1'b0);
      for (int k = 0; k < 64; k++) blk(2'b01, k == 63, 1'b0);
      drain();
      chk("mis_slips", 64'(slips - s0), 64'd1);
      chk("mis_lock", 64'(rx_block_lock), 64'd1);

      // loss of lock on the 16th bad header of a window
      s0 = slips;
      for (int k = 0; k < 35; k++)
         blk((k % 2 == 0 && k < 32) ? 2'b00 : 2'b01, k < 30, k == 30);
      drain();
      chk("lol_lock", 64'(rx_block_lock), 64'd0);
      chk("lol_slips", 64'(slips - s0), 64'd1);

      // 15 bad headers per window, last one on the window boundary
      do_reset();
      for (int k = 0; k < 64; k++) blk(2'b01, k == 63, 1'b0);
      e0 = errs;
      s0 = slips;
      for (int w = 0; w < 3; w++)
         for (int k = 0; k < 64; k++)
            blk((k >= 7 && k % 4 == 3) ? 2'b11 : 2'b10, 1'b1, 1'b0);
      drain();
      chk("tol_errs", 64'(errs - e0), 64'd45);
      chk("tol_slips", 64'(slips - s0), 64'd0);
      chk("tol_lock", 64'(rx_block_lock), 64'd1);

      // asynchronous reset while locked and streaming
      for (int k = 0; k < 5; k++) blk(2'b01, 1'b1, 1'b0);
      #2;
      chk("pre_rst_lock", 64'(rx_block_lock), 64'd1);
      rst_n = 1'b0;
      serdes_rx_valid = 1'b0;
      q.delete();
      nblk = 0;
      #1;
      chk_zero("async_rst");
      @(posedge CLK); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 64; k++) blk(2'b01, k == 63, 1'b0);
      drain();
      chk("relock", 64'(rx_block_lock), 64'd1);

      // 16 invalid headers inside one BER window
      do_reset();
      for (int i = 0; i < 16; i++) blk(2'b00, 1'b0, i % 5 == 0);
      drain();
`ifdef RX_BER_MON_EN
      chk("high_ber", 64'(rx_high_ber), 64'd1);
`else
      chk("high_ber", 64'(rx_high_ber), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
